// File: rtl/cla_nibble_sequencer_pkg.sv
// cla_nibble_sequencer_pkg: shared FSM encoding, nibble width and index sizing
package cla_nibble_sequencer_pkg;
    localparam int NIBBLE_W = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;
    function automatic int idx_w(input int width);
        return $clog2(width / NIBBLE_W);
    endfunction
endpackage

// File: rtl/cla_nibble_sequencer_slice.sv
// cla4_slice: 4-bit generate/propagate carry-lookahead adder slice
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] g, p;
    logic c1, c2;
    assign g  = x & y;
    assign p  = x ^ y;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: multi-cycle wide adder reusing one 4-bit lookahead slice per nibble
module cla_nibble_sequencer
    import cla_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_w(WIDTH);
    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [WIDTH-1:0] ra, rb;
    logic [3:0]      x, y, s;
    logic            co, c3, last;
    assign x         = ra[idx*NIBBLE_W +: NIBBLE_W];
    assign y         = rb[idx*NIBBLE_W +: NIBBLE_W];
    assign last      = idx == IW'(NIB - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    cla4_slice u_slice (.x(x), .y(y), .ci(carry), .s(s), .co(co), .c3(c3));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra    <= a;
                    rb    <= b;
                    carry <= cin;
                    idx   <= '0;
                    sum   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= s;
                    carry <= co;
                    // hold idx on the final nibble so it never wraps mid-operation
                    idx   <= last ? idx : idx + 1'b1;
                    if (last) begin
                        cout  <= co;
                        ovf   <= c3 ^ co;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
